// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared instruction constants and receiver FSM encoding
// Purpose: constants common to the input-side instruction builders and the
//          interrupt receiver, plus the receiver state encoding.
// Ports:   none (package)
package io_ctrl_pkg;

  localparam logic [31:0] JUMP_KEY_INSTR  = 32'h0040_00EF;
  localparam logic [31:0] FRAME_RDY_INSTR = 32'h0080_00EF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OFFER      = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_fifo.sv
// rtl/irq_fifo.sv - pending-interrupt FIFO
// Purpose: DEPTH-entry queue of 32-bit interrupt instructions.
// Ports:   proc_clk, reset_n   clock / async active-low reset
//          push, push_data     write request (ignored when full unless popping)
//          pop                 remove head entry
//          head                current head entry
//          count, full, empty  occupancy
module irq_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          proc_clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = CW - 1;

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop on the same edge frees the slot, so a full queue still takes the push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointers carry one extra bit so full and empty are distinguishable;
  // the low AW bits index storage, i.e. wrap modulo DEPTH.
  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge proc_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/interrupt_receiver.sv
// rtl/interrupt_receiver.sv - queues interrupt instructions and injects them into fetch
// Purpose: captures one-cycle interrupt events, queues them, offers the head to
//          the CPU fetch stage and blocks further injection until the handler
//          returns. Optional macro FRAME_COALESCE_EN keeps at most one queued
//          frame-ready event.
// Ports:   proc_clk, reset_n   clock / async active-low reset
//          irq_instr           event instruction, nonzero for one cycle
//          inject_ready        fetch accepts the offered instruction
//          isr_done            handler-return pulse
//          inject_valid        instruction offered to fetch
//          inject_instr        offered instruction, zero when not valid
//          in_service          handler executing
//          pending_count       queued entries
//          overflow            sticky: an event was dropped on a full queue
import io_ctrl_pkg::*;

module interrupt_receiver #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          proc_clk,
  input  logic          reset_n,
  input  logic [31:0]   irq_instr,
  input  logic          inject_ready,
  input  logic          isr_done,
  output logic          inject_valid,
  output logic [31:0]   inject_instr,
  output logic          in_service,
  output logic [CW-1:0] pending_count,
  output logic          overflow
);

  irq_state_t    state;
  irq_state_t    state_next;
  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic          full;
  logic          empty;

`ifdef FRAME_COALESCE_EN
  logic frame_pending;
  logic is_frame;
  logic pop_frame;
  logic coalesce_drop;

  assign is_frame  = (irq_instr == FRAME_RDY_INSTR);
  assign pop_frame = pop && (head == FRAME_RDY_INSTR);
  // A queued frame event leaving on this same edge no longer counts as pending.
  assign coalesce_drop = is_frame && frame_pending && !pop_frame;
  assign push = (irq_instr != '0) && !coalesce_drop;

  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_pending <= 1'b0;
    end else begin
      frame_pending <= (frame_pending && !pop_frame) ||
                       (push && is_frame && (!full || pop));
    end
  end
`else
  assign push = (irq_instr != '0);
`endif

  irq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .proc_clk  (proc_clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (irq_instr),
    .pop       (pop),
    .head      (head),
    .count     (pending_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // isr_done only matters in IN_SERVICE, so a new injection never nests.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:       if (!empty) state_next = OFFER;
      OFFER: begin
        if (inject_ready) begin
          pop        = 1'b1;
          state_next = IN_SERVICE;
        end
      end
      IN_SERVICE: if (isr_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign inject_valid = (state == OFFER);
  assign inject_instr = (state == OFFER) ? head : 32'b0;
  assign in_service   = (state == IN_SERVICE);

endmodule

// File: doc/interrupt_receiver.md
INTERRUPT_RECEIVER -- requirements
Module: interrupt_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the pending-interrupt FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter CW, default 3, meaning the pending_count width, equal to log2(DEPTH)+1.
REQ-003 SHALL have port proc_clk, input, 1, the single processor clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port irq_instr, input, 32, interrupt instruction from the input controller; nonzero for one cycle marks an event, 32'b0 means none.
REQ-006 SHALL have port inject_ready, input, 1, the CPU fetch stage can accept an injected instruction this cycle.
REQ-007 SHALL have port isr_done, input, 1, one-cycle pulse from the CPU when the handler returns.
REQ-008 SHALL have port inject_valid, output, 1, inject_instr is being offered to fetch.
REQ-009 SHALL have port inject_instr, output, 32, head-of-queue instruction; 32'b0 when inject_valid is low.
REQ-010 SHALL have port in_service, output, 1, a handler is executing.
REQ-011 SHALL have port pending_count, output, CW, the number of queued entries.
REQ-012 SHALL have port overflow, output, 1, sticky flag indicating an event was dropped because the queue was full.

Function
REQ-013 SHALL push irq_instr into the FIFO on every rising edge where irq_instr != 0, with no handshake, since the source pulses for one cycle only.
REQ-014 SHALL implement FSM states IDLE, OFFER, IN_SERVICE.
REQ-015 SHALL go IDLE->OFFER on the first edge where the FIFO is non-empty, so inject_valid is high one cycle after an entry is written into an empty queue (an event sampled at edge E0 gives inject_valid=1 after E1).
REQ-016 SHALL, in OFFER, hold inject_valid=1 and inject_instr=FIFO head stable until inject_ready=1.
REQ-017 SHALL, on an edge where OFFER and inject_ready=1, pop the head and go to IN_SERVICE.
REQ-018 SHALL, in IN_SERVICE, hold inject_valid=0 and in_service=1, and go to IDLE on isr_done=1.
REQ-019 SHALL ignore isr_done in IDLE and OFFER, so nested interrupts are never injected.
REQ-020 SHALL accept both a push and a pop on the same edge when full; the count is unchanged and overflow is not set.
REQ-021 SHALL, on a push when full without a pop, drop the new event, keep the count at DEPTH and set overflow=1; overflow clears only on reset.
REQ-022 SHALL wrap read and write pointers modulo DEPTH, with pending_count = write - read using CW-bit arithmetic.
REQ-023 SHALL allow isr_done and irq_instr in the same cycle, so the push is captured while returning to IDLE.

Reset
REQ-024 SHALL, on reset_n=0, immediately force: state IDLE, FIFO empty, inject_valid=0, inject_instr=0, in_service=0, pending_count=0, overflow=0.
REQ-025 SHALL discard queued and in-flight entries when reset occurs mid-OFFER or mid-IN_SERVICE.
REQ-026 SHALL resume normal operation on the first rising edge after reset_n deasserts.

Configuration
REQ-027 SHALL, with FRAME_COALESCE_EN defined, drop an incoming FRAME_RDY_INSTR if one is already queued and not yet popped; this drop SHALL NOT set overflow.
REQ-028 SHALL, without FRAME_COALESCE_EN, queue every frame-ready event like any other event.

Structure
REQ-029 SHALL take JUMP_KEY_INSTR, FRAME_RDY_INSTR and the FSM state encoding from shared package io_ctrl_pkg, the same constants the input-side instruction builders use.
REQ-030 SHALL implement the FIFO as one sub-module, irq_fifo (push, pop, head, count, full, empty); the FSM and flags live in the top level.

Verification
REQ-031 Single event: irq_instr=JUMP_KEY_INSTR for 1 cycle with inject_ready=1 -> inject_valid high 1 cycle after capture, then in_service=1, pending_count=0.
REQ-032 Backpressure: inject_ready=0 for 10 cycles, then 1 -> inject_instr stable for all 10 cycles, exactly one pop.
REQ-033 Overflow: DEPTH=4, inject_ready=0, 5 distinct events -> pending_count=4, overflow=1, FIFO order holds the first 4.
REQ-034 Full with simultaneous push and pop -> count stays 4, overflow=0, the new entry appears last.
REQ-035 FRAME_COALESCE_EN: two FRAME_RDY_INSTR events while one is pending -> pending_count=1, overflow=0; without the macro -> pending_count=2.
REQ-036 Reset mid-IN_SERVICE with 2 entries queued -> all outputs 0 asynchronously; no injection after release until a new event arrives.
